// File: rtl/add_sub_pipe_pkg.sv
// Shared types for the pipelined add/subtract/compare unit: operation codes,
// the flag bundle and a small decode helper.
package add_sub_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SLT  = 2'd2,
    OP_SLTU = 2'd3
  } op_e;

  typedef struct packed {
    logic v;
    logic c;
    logic z;
    logic s;
  } flags_t;

  // SUB, SLT and SLTU all run the adder as a + ~b + 1.
  function automatic logic is_sub(op_e op);
    return op != OP_ADD;
  endfunction

endpackage

// File: rtl/add_sub_pipe_if.sv
// Request/response bundle of add_sub_pipe; the master issues operations and
// consumes results, the slave is the pipeline itself.
interface add_sub_pipe_if
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_v;
  logic             flag_c;
  logic             flag_z;
  logic             flag_s;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_v, flag_c, flag_z, flag_s
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_v, flag_c, flag_z, flag_s
  );

endinterface

// File: rtl/add_sub_pipe_seg.sv
// One carry-chain segment: a combinational SEG_W-bit adder that also exposes
// the carry into its MSB so the top segment can form the overflow flag.
module add_sub_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] x,
  input  logic [SEG_W-1:0] y,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SEG_W-1:0] low;
  logic [1:0]       high;

  // Split at the MSB so the carry into it is visible without a second adder.
  assign low  = {1'b0, x[SEG_W-2:0]} + {1'b0, y[SEG_W-2:0]} + SEG_W'(cin);
  assign high = {1'b0, x[SEG_W-1]} + {1'b0, y[SEG_W-1]} + {1'b0, low[SEG_W-1]};

  assign sum      = {high[0], low[SEG_W-2:0]};
  assign c_msb_in = low[SEG_W-1];
  assign cout     = high[1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub/compare unit: the carry chain is cut into STAGES registered
// segments, the whole pipe advancing together under downstream back-pressure.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic           clk,
  input logic           rst_n,
  add_sub_pipe_if.slave bus
);

  localparam int SEG_W = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > 8) || (WIDTH % STAGES != 0) || (SEG_W < 4)) begin : g_bad_param
    $error("add_sub_pipe: WIDTH must split into 1..8 segments of at least 4 bits");
  end

  logic             adv;
  logic             fin_valid_q;
  op_e              fin_op_q;
  logic [WIDTH-1:0] fin_sum_q;
  logic             fin_carry_q;
  logic             fin_cmsb_q;

  // The pipe only moves as a unit: a held result freezes every stage behind it.
  assign adv          = ~fin_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG_W;
    localparam int HI_W = WIDTH - LO;

    logic [HI_W-1:0]     x_in;
    logic [HI_W-1:0]     y_in;
    logic                cin;
    logic                valid_in;
    op_e                 op_in;
    logic [SEG_W-1:0]    seg_sum;
    logic                seg_cout;
    logic                seg_cmsb;
    logic [LO+SEG_W-1:0] sum_cur;

    if (k == 0) begin : g_head
      // NOTE: every signal is assigned on every path through always_comb, so no latch can form.
      always_comb begin
        valid_in = bus.in_valid;
        op_in    = bus.op;
        x_in     = bus.a;
        cin      = is_sub(bus.op);
        y_in     = cin ? ~bus.b : bus.b;
      end
      assign sum_cur = seg_sum;
    end else begin : g_tail
      assign valid_in = g_stage[k-1].g_mid.valid_q;
      assign op_in    = g_stage[k-1].g_mid.op_q;
      assign x_in     = g_stage[k-1].g_mid.x_q;
      assign y_in     = g_stage[k-1].g_mid.y_q;
      assign cin      = g_stage[k-1].g_mid.carry_q;
      assign sum_cur  = {seg_sum, g_stage[k-1].g_mid.sum_q};
    end

    add_sub_seg #(
      .SEG_W(SEG_W)
    ) u_seg (
      .x        (x_in[SEG_W-1:0]),
      .y        (y_in[SEG_W-1:0]),
      .cin      (cin),
      .sum      (seg_sum),
      .cout     (seg_cout),
      .c_msb_in (seg_cmsb)
    );

    if (k < STAGES - 1) begin : g_mid
      logic                 valid_q;
      op_e                  op_q;
      logic [HI_W-SEG_W-1:0] x_q;
      logic [HI_W-SEG_W-1:0] y_q;
      logic [LO+SEG_W-1:0]  sum_q;
      logic                 carry_q;
      logic                 unused_cmsb;

      // Carry into a segment MSB only matters for the top segment.
      assign unused_cmsb = seg_cmsb;

      // NOTE: pipeline data is reset together with the valid bits; it is cheap
      // here and keeps every stage defined from the first cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          op_q    <= OP_ADD;
          x_q     <= '0;
          y_q     <= '0;
          sum_q   <= '0;
          carry_q <= 1'b0;
        end else if (adv) begin
          // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
          valid_q <= valid_in;
          op_q    <= op_in;
          x_q     <= x_in[HI_W-1:SEG_W];
          y_q     <= y_in[HI_W-1:SEG_W];
          sum_q   <= sum_cur;
          carry_q <= seg_cout;
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fin_valid_q <= 1'b0;
          fin_op_q    <= OP_ADD;
          fin_sum_q   <= '0;
          fin_carry_q <= 1'b0;
          fin_cmsb_q  <= 1'b0;
        end else if (adv) begin
          fin_valid_q <= valid_in;
          fin_op_q    <= op_in;
          fin_sum_q   <= sum_cur;
          fin_carry_q <= seg_cout;
          fin_cmsb_q  <= seg_cmsb;
        end
      end
    end
  end

  flags_t           flags;
  logic [WIDTH-1:0] res;

  always_comb begin
    flags.c = fin_carry_q;
    flags.v = fin_cmsb_q ^ fin_carry_q;
    flags.s = fin_sum_q[WIDTH-1];
    flags.z = (fin_sum_q == '0);
    res     = fin_sum_q;
    case (fin_op_q)
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, flags.s ^ flags.v};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, ~flags.c};
      default: res = fin_sum_q;
    endcase
  end

  // Outputs read as zero whenever no result is being presented.
  assign bus.out_valid = fin_valid_q;
  assign bus.result    = fin_valid_q ? res : '0;
  assign bus.flag_v    = fin_valid_q & flags.v;
  assign bus.flag_c    = fin_valid_q & flags.c;
  assign bus.flag_z    = fin_valid_q & flags.z;
  assign bus.flag_s    = fin_valid_q & flags.s;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe: a 4-stage and a 1-stage instance driven by
// hand-computed vectors, a back-pressured stream and a mid-stream reset.
module tb_add_sub_pipe;
  import add_sub_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  add_sub_pipe_if #(.WIDTH(32)) bus4 ();
  add_sub_pipe_if #(.WIDTH(32)) bus1 ();

  add_sub_pipe #(.WIDTH(32), .STAGES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  add_sub_pipe #(.WIDTH(32), .STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] flags4();
    return {bus4.flag_v, bus4.flag_c, bus4.flag_z, bus4.flag_s};
  endfunction

  // Golden model: {result, v, c, z, s}; overflow and compares derived from operand signs.
  function automatic logic [35:0] model(op_e op, logic [31:0] a, logic [31:0] b);
    logic [32:0] full;
    logic        sub, v, c, z, s;
    logic [31:0] r;
    sub  = (op != OP_ADD);
    full = {1'b0, a} + {1'b0, sub ? ~b : b} + 33'(sub);
    c    = full[32];
    s    = full[31];
    z    = (full[31:0] == 32'd0);
    v    = sub ? ((a[31] != b[31]) && (s != a[31])) : ((a[31] == b[31]) && (s != a[31]));
    case (op)
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'd0, a < b};
      default: r = full[31:0];
    endcase
    return {r, v, c, z, s};
  endfunction

  task automatic do_op(input bit sel, input op_e op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic [3:0] flg);
    @(posedge clk); #1;
    if (sel) begin
      bus1.in_valid = 1'b1; bus1.op = op; bus1.a = a; bus1.b = b; bus1.out_ready = 1'b1;
    end else begin
      bus4.in_valid = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b; bus4.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!(sel ? bus1.out_valid : bus4.out_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(sel ? bus1.out_valid : bus4.out_valid)) lat = -1;
    res = sel ? bus1.result : bus4.result;
    flg = sel ? {bus1.flag_v, bus1.flag_c, bus1.flag_z, bus1.flag_s} : flags4();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({bus4.out_valid, bus4.result, flags4(), bus4.in_ready} !== {1'b0, 32'd0, 4'd0, 1'b1}) begin
      $display("FAIL reset_s4: ov=%b res=%h flags=%b rdy=%b, want 0 0 0000 1",
               bus4.out_valid, bus4.result, flags4(), bus4.in_ready);
      n_err++;
    end
    n_vec++;
    if ({bus1.out_valid, bus1.result, bus1.flag_v, bus1.flag_c, bus1.flag_z, bus1.flag_s, bus1.in_ready}
        !== {1'b0, 32'd0, 4'd0, 1'b1}) begin
      $display("FAIL reset_s1: ov=%b res=%h rdy=%b, want 0 0 1", bus1.out_valid, bus1.result, bus1.in_ready);
      n_err++;
    end
    #10 rst_n = 1'b1;
  endtask

  // Single ops on the 4-stage unit: {name, op, a, b, result, vczs}
  task automatic test_arith();
    string       names [7] = '{"add_ovf", "add_segcarry", "sub_zero", "sub_neg", "slt_neg", "sltu_big", "slt_ovf"};
    op_e         ops   [7] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SLT, OP_SLTU, OP_SLT};
    logic [31:0] as    [7] = '{32'h7FFFFFFF, 32'h00FFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] bs    [7] = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'd1, 32'h7FFFFFFF};
    logic [31:0] exp_r [7] = '{32'h80000000, 32'h01000000, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1};
    logic [3:0]  exp_f [7] = '{4'b1001, 4'b0000, 4'b0110, 4'b0001, 4'b0101, 4'b0101, 4'b1100};
    int          lat;
    logic [31:0] res;
    logic [3:0]  flg;
    for (int i = 0; i < 7; i++) begin
      do_op(1'b0, ops[i], as[i], bs[i], lat, res, flg);
      n_vec++;
      if (lat !== 4 || res !== exp_r[i] || flg !== exp_f[i]) begin
        $display("FAIL %s: lat=%0d res=%h vczs=%b, want lat=4 res=%h vczs=%b",
                 names[i], lat, res, flg, exp_r[i], exp_f[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_back_to_back();
    op_e          ops [8];
    logic [31:0]  as  [8];
    logic [31:0]  bs  [8];
    logic [35:0]  exp_q [$];
    logic [35:0]  exp;
    int           n_sent = 0;
    int           n_got  = 0;
    int           cyc    = 0;
    int           extra  = 0;
    for (int i = 0; i < 8; i++) begin
      ops[i] = op_e'($urandom_range(0, 3));
      as[i]  = $urandom();
      bs[i]  = (i == 3) ? as[i] : $urandom();
    end
    @(posedge clk); #1;
    while (n_got < 8 && cyc < 200) begin
      bus4.out_ready = (cyc % 2 == 0);
      if (n_sent < 8) begin
        bus4.in_valid = 1'b1; bus4.op = ops[n_sent]; bus4.a = as[n_sent]; bus4.b = bs[n_sent];
      end else begin
        bus4.in_valid = 1'b0;
      end
      #1;
      n_vec++;
      if (bus4.in_ready !== !(bus4.out_valid && !bus4.out_ready)) begin
        $display("FAIL stream_in_ready cyc %0d: in_ready=%b with out_valid=%b out_ready=%b",
                 cyc, bus4.in_ready, bus4.out_valid, bus4.out_ready);
        n_err++;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hX;
        n_vec++;
        if ({bus4.result, flags4()} !== exp) begin
          $display("FAIL stream_result #%0d: res=%h vczs=%b, want res=%h vczs=%b",
                   n_got, bus4.result, flags4(), exp[35:4], exp[3:0]);
          n_err++;
        end
        n_got++;
      end
      if (bus4.in_valid && bus4.in_ready) begin
        exp_q.push_back(model(ops[n_sent], as[n_sent], bs[n_sent]));
        n_sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    n_vec++;
    if (n_got !== 8) begin
      $display("FAIL stream_count: got %0d results, want 8", n_got);
      n_err++;
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus4.out_valid) extra++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (extra !== 0) begin
      $display("FAIL stream_repeat: %0d extra results after stream, want 0", extra);
      n_err++;
    end
  endtask

  task automatic test_reset_midstream();
    int          seen = 0;
    int          lat;
    logic [31:0] res;
    logic [3:0]  flg;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus4.in_valid = 1'b1; bus4.op = OP_ADD; bus4.a = 32'd10 + 32'(i); bus4.b = 32'd20;
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if ({bus4.out_valid, bus4.result, bus4.in_ready} !== {1'b1, 32'd30, 1'b0}) begin
      $display("FAIL stall_hold: ov=%b res=%h rdy=%b, want 1 0000001e 0",
               bus4.out_valid, bus4.result, bus4.in_ready);
      n_err++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus4.out_valid, bus4.result, flags4(), bus4.in_ready} !== {1'b0, 32'd0, 4'd0, 1'b1}) begin
      $display("FAIL async_reset: ov=%b res=%h flags=%b rdy=%b, want 0 0 0000 1",
               bus4.out_valid, bus4.result, flags4(), bus4.in_ready);
      n_err++;
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus4.out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      $display("FAIL stale_after_reset: %0d cycles with out_valid, want 0", seen);
      n_err++;
    end
    do_op(1'b0, OP_SUB, 32'd100, 32'd58, lat, res, flg);
    n_vec++;
    if (lat !== 4 || res !== 32'd42 || flg !== 4'b0100) begin
      $display("FAIL post_reset_op: lat=%0d res=%h vczs=%b, want lat=4 res=0000002a vczs=0100",
               lat, res, flg);
      n_err++;
    end
  endtask

  task automatic test_single_stage();
    int          lat;
    logic [31:0] res;
    logic [3:0]  flg;
    do_op(1'b1, OP_ADD, 32'hFFFFFFFF, 32'd1, lat, res, flg);
    n_vec++;
    if (lat !== 1 || res !== 32'd0 || flg !== 4'b0110) begin
      $display("FAIL s1_add_wrap: lat=%0d res=%h vczs=%b, want lat=1 res=00000000 vczs=0110",
               lat, res, flg);
      n_err++;
    end
    do_op(1'b1, OP_SLT, 32'h80000000, 32'h7FFFFFFF, lat, res, flg);
    n_vec++;
    if (lat !== 1 || res !== 32'd1 || flg !== 4'b1100) begin
      $display("FAIL s1_slt_ovf: lat=%0d res=%h vczs=%b, want lat=1 res=00000001 vczs=1100",
               lat, res, flg);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus4.in_valid = 1'b0; bus4.op = OP_ADD; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.op = OP_ADD; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_reset_midstream();
    test_single_stage();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
